// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: sequencer state encodings and the
// hard-wired zero register number.
package cpu_pipe_pkg;

    // Sequencer state encodings; 2'd3 is unused and treated as illegal.
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Register $0 is hard-wired to zero, so a load into it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from ID/EX and pipeline-control outputs of the stall sequencer.
// All signals are level-sampled every clock; there is no valid/ready handshake.
// The pipeline side (master) drives the hazard inputs, the sequencer (slave)
// drives the enables, flush, bubble and freeze back.
interface hazard_stall_ctrl_if;

    logic [4:0] ID_instr_25_21;
    logic [4:0] ID_instr_20_16;
    logic       ID_uses_rt;
    logic       ID_branch_taken;
    logic       EX_mem_read;
    logic [4:0] EX_instr_20_16;
    logic       mem_busy;

    logic       pc_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_bubble;
    logic       pipe_freeze;

    modport master (
        output ID_instr_25_21, ID_instr_20_16, ID_uses_rt, ID_branch_taken,
               EX_mem_read, EX_instr_20_16, mem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze
    );

    modport slave (
        input  ID_instr_25_21, ID_instr_20_16, ID_uses_rt, ID_branch_taken,
               EX_mem_read, EX_instr_20_16, mem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads.
module hazard_detect
    import cpu_pipe_pkg::*;
(
    input  logic [4:0] ID_instr_25_21,
    input  logic [4:0] ID_instr_20_16,
    input  logic       ID_uses_rt,
    input  logic       EX_mem_read,
    input  logic [4:0] EX_instr_20_16,
    output logic       load_use
);

    // rs is always a source; rt only counts when the decoder says it is read.
    always_comb begin
        load_use = EX_mem_read &&
                   (EX_instr_20_16 != REG_ZERO) &&
                   ((EX_instr_20_16 == ID_instr_25_21) ||
                    (ID_uses_rt && (EX_instr_20_16 == ID_instr_20_16)));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: post-reset fill, load-use stalls,
// taken-branch flushes and data-memory wait states. Outputs are decoded
// combinationally from the registered state and the current hazard inputs.
module hazard_stall_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int INIT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave hif,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [3:0] INIT_RELOAD  = 4'(INIT_CYCLES - 1);
    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    logic [1:0] state, state_nxt;
    logic [3:0] init_cnt, init_cnt_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;
    logic       load_use;

    hazard_detect u_hazard_detect (
        .ID_instr_25_21 (hif.ID_instr_25_21),
        .ID_instr_20_16 (hif.ID_instr_20_16),
        .ID_uses_rt     (hif.ID_uses_rt),
        .EX_mem_read    (hif.EX_mem_read),
        .EX_instr_20_16 (hif.EX_instr_20_16),
        .load_use       (load_use)
    );

    // Output decode and next-state; priority INIT > mem_busy > load-use > branch > normal.
    always_comb begin
        hif.pc_write     = 1'b1;
        hif.IF_ID_write  = 1'b1;
        hif.IF_ID_flush  = 1'b0;
        hif.ID_EX_bubble = 1'b0;
        hif.pipe_freeze  = 1'b0;
        state_nxt        = state;
        init_cnt_nxt     = init_cnt;
        flush_cnt_nxt    = flush_cnt;

        case (state)
            ST_INIT: begin
                hif.pc_write     = 1'b0;
                hif.IF_ID_write  = 1'b0;
                hif.IF_ID_flush  = 1'b1;
                hif.ID_EX_bubble = 1'b1;
                if (init_cnt == 4'd0) begin
                    state_nxt = ST_RUN;
                end else begin
                    init_cnt_nxt = init_cnt - 4'd1;
                end
            end

            ST_RUN: begin
                if (hif.mem_busy) begin
                    hif.pipe_freeze = 1'b1;
                    hif.pc_write    = 1'b0;
                    hif.IF_ID_write = 1'b0;
                end else if (load_use) begin
                    // The bubble clears EX_mem_read next cycle, so this lasts one cycle.
                    hif.pc_write     = 1'b0;
                    hif.IF_ID_write  = 1'b0;
                    hif.ID_EX_bubble = 1'b1;
                end else if (hif.ID_branch_taken) begin
                    hif.IF_ID_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end
            end

            ST_FLUSH: begin
                if (hif.mem_busy) begin
                    hif.pipe_freeze = 1'b1;
                    hif.pc_write    = 1'b0;
                    hif.IF_ID_write = 1'b0;
                end else begin
                    // Wrong-path instructions are being discarded; their hazards do not matter.
                    hif.IF_ID_flush = 1'b1;
                    if (flush_cnt == 2'd0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 2'd1;
                    end
                end
            end

            default: begin
                // Illegal encoding: hold the front end safely for one cycle and resume in RUN.
                hif.pc_write     = 1'b0;
                hif.IF_ID_write  = 1'b0;
                hif.IF_ID_flush  = 1'b1;
                hif.ID_EX_bubble = 1'b1;
                state_nxt        = ST_RUN;
            end
        endcase
    end

    // Sequencer state and its dwell counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= INIT_RELOAD;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!hif.pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a main instance (FLUSH_CYCLES=2) and a
// narrow-counter instance sharing the same inputs for saturation checks.
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    hazard_stall_ctrl_if hif ();
    hazard_stall_ctrl_if sif ();

    logic [1:0]  ctrl_state;
    logic [31:0] stall_cnt;
    logic [1:0]  s_state;
    logic [2:0]  s_cnt;

    // Second instance sees exactly the same hazard inputs.
    assign sif.ID_instr_25_21  = hif.ID_instr_25_21;
    assign sif.ID_instr_20_16  = hif.ID_instr_20_16;
    assign sif.ID_uses_rt      = hif.ID_uses_rt;
    assign sif.ID_branch_taken = hif.ID_branch_taken;
    assign sif.EX_mem_read     = hif.EX_mem_read;
    assign sif.EX_instr_20_16  = hif.EX_instr_20_16;
    assign sif.mem_busy        = hif.mem_busy;

    hazard_stall_ctrl #(.INIT_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hif        (hif),
        .ctrl_state (ctrl_state),
        .stall_cnt  (stall_cnt)
    );

    hazard_stall_ctrl #(.INIT_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .hif        (sif),
        .ctrl_state (s_state),
        .stall_cnt  (s_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock: lands 1 time unit after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.ID_instr_25_21  = 5'd0;
        hif.ID_instr_20_16  = 5'd0;
        hif.ID_uses_rt      = 1'b0;
        hif.ID_branch_taken = 1'b0;
        hif.EX_mem_read     = 1'b0;
        hif.EX_instr_20_16  = 5'd0;
        hif.mem_busy        = 1'b0;
    endtask

    // Packed {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze}
    function automatic logic [31:0] ctl();
        return {27'd0, hif.pc_write, hif.IF_ID_write, hif.IF_ID_flush,
                hif.ID_EX_bubble, hif.pipe_freeze};
    endfunction

    localparam logic [31:0] C_INIT   = 32'b00110;
    localparam logic [31:0] C_NORM   = 32'b11000;
    localparam logic [31:0] C_STALL  = 32'b00010;
    localparam logic [31:0] C_FLUSH  = 32'b11100;
    localparam logic [31:0] C_FREEZE = 32'b00001;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1;
        // Reset state
        check("rst_ctl", ctl(), C_INIT);
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        // mem_busy is ignored while held in reset / INIT
        hif.mem_busy = 1'b1;
        #1;
        check("rst_busy_ignored", ctl(), C_INIT);
        hif.mem_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // 1. INIT dwell of exactly 4 cycles
        for (int i = 0; i < 4; i++) begin
            check("init_ctl", ctl(), C_INIT);
            check("init_state", 32'(ctrl_state), 32'd0);
            tick();
        end
        check("run_state", 32'(ctrl_state), 32'd1);
        check("run_ctl", ctl(), C_NORM);
        check("init_stall_cnt", stall_cnt, 32'd4);

        // 2. Load to $5 with ID rs=5 -> one stall cycle
        hif.EX_mem_read    = 1'b1;
        hif.EX_instr_20_16 = 5'd5;
        hif.ID_instr_25_21 = 5'd5;
        hif.ID_instr_20_16 = 5'd7;
        #1;
        check("lu_rs_ctl", ctl(), C_STALL);
        tick();
        hif.EX_mem_read = 1'b0;
        #1;
        check("lu_rs_after_ctl", ctl(), C_NORM);
        check("lu_rs_after_state", 32'(ctrl_state), 32'd1);
        check("lu_rs_cnt", stall_cnt, 32'd5);
        // Destination $0 never stalls
        hif.EX_mem_read    = 1'b1;
        hif.EX_instr_20_16 = 5'd0;
        hif.ID_instr_25_21 = 5'd0;
        #1;
        check("lu_r0_ctl", ctl(), C_NORM);
        tick();

        // 3. rt match only stalls when rt is a source
        hif.EX_mem_read    = 1'b1;
        hif.EX_instr_20_16 = 5'd5;
        hif.ID_instr_25_21 = 5'd3;
        hif.ID_instr_20_16 = 5'd5;
        hif.ID_uses_rt     = 1'b0;
        #1;
        check("lu_rt_unused_ctl", ctl(), C_NORM);
        hif.ID_uses_rt = 1'b1;
        #1;
        check("lu_rt_used_ctl", ctl(), C_STALL);
        tick();
        clear_inputs();
        #1;
        check("lu_rt_cnt", stall_cnt, 32'd6);
        check("sat_cnt_6", 32'(s_cnt), 32'd6);

        // 4. Taken branch -> two flush cycles, RUN->FLUSH->RUN
        hif.ID_branch_taken = 1'b1;
        #1;
        check("br0_ctl", ctl(), C_FLUSH);
        check("br0_state", 32'(ctrl_state), 32'd1);
        tick();
        hif.ID_branch_taken = 1'b0;
        #1;
        check("br1_ctl", ctl(), C_FLUSH);
        check("br1_state", 32'(ctrl_state), 32'd2);
        tick();
        check("br2_ctl", ctl(), C_NORM);
        check("br2_state", 32'(ctrl_state), 32'd1);

        // 5. mem_busy for 3 cycles inside FLUSH, with a load-use present
        hif.ID_branch_taken = 1'b1;
        tick();
        hif.ID_branch_taken = 1'b0;
        hif.mem_busy        = 1'b1;
        hif.EX_mem_read     = 1'b1;
        hif.EX_instr_20_16  = 5'd9;
        hif.ID_instr_25_21  = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_ctl", ctl(), C_FREEZE);
            check("busy_state", 32'(ctrl_state), 32'd2);
            tick();
        end
        clear_inputs();
        #1;
        check("busy_resume_ctl", ctl(), C_FLUSH);
        check("busy_resume_state", 32'(ctrl_state), 32'd2);
        check("busy_cnt", stall_cnt, 32'd9);
        check("sat_cnt_7", 32'(s_cnt), 32'd7);
        tick();
        check("busy_end_state", 32'(ctrl_state), 32'd1);
        check("busy_end_ctl", ctl(), C_NORM);

        // Further stalls on the narrow counter must not wrap
        hif.EX_mem_read    = 1'b1;
        hif.EX_instr_20_16 = 5'd4;
        hif.ID_instr_25_21 = 5'd4;
        tick();
        clear_inputs();
        #1;
        check("sat_nowrap", 32'(s_cnt), 32'd7);
        check("wide_cnt_10", stall_cnt, 32'd10);

        // 6. Asynchronous reset in the middle of a flush
        hif.ID_branch_taken = 1'b1;
        tick();
        hif.ID_branch_taken = 1'b0;
        #1;
        check("pre_rst_state", 32'(ctrl_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", ctl(), C_INIT);
        check("async_rst_state", 32'(ctrl_state), 32'd0);
        check("async_rst_cnt", stall_cnt, 32'd0);
        check("async_rst_sat", 32'(s_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("rerun_state", 32'(ctrl_state), 32'd1);
        check("rerun_cnt", stall_cnt, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
